fflags_commit_drain: RTL

Read-side controller for the 7-entry, 5-bit floating-point exception-flag row store. It allocates rows in order, records when each row's flags have been written, and drains rows in order through the store's read port into a one-entry commit register. It accumulates committed flags into the sticky accrued-exception value (fcsr.fflags) and sits between the FP writeback path that fills the store and the commit/CSR logic.

---
 rtl/fflags_pkg.sv | 18 +
 rtl/fflags_row_tracker.sv | 50 +++++
 rtl/fflags_commit_drain.sv | 65 ++++++
 3 files changed

// File: rtl/fflags_pkg.sv
// fflags_pkg: shared sizes, flag bit positions and commit record for the fflags row store.
package fflags_pkg;
  localparam int ENTRIES = 7;
  localparam int FLAG_W = 5;
  localparam int ADDR_W = 3;
  localparam int NX = 0;
  localparam int UF = 1;
  localparam int OF = 2;
  localparam int DZ = 3;
  localparam int NV = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [FLAG_W-1:0] flags;
  } commit_rec_t;
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/fflags_row_tracker.sv
// fflags_row_tracker: in-order row pointers, occupancy and per-row valid/done bits.
module fflags_row_tracker
  import fflags_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc,
  input  logic              free,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] tail,
  output logic              full,
  output logic              head_ready
);
  logic [ENTRIES-1:0] valid, done;
  logic [ADDR_W:0]    count;
  assign full = count == (ADDR_W + 1)'(ENTRIES);
  assign head_ready = valid[head] & done[head];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= next_ptr(tail);
      end
      if (wb_valid && valid[wb_addr]) done[wb_addr] <= 1'b1;
      // a free of the head row must win over a same-edge write to it
      if (free) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= next_ptr(head);
      end
      count <= count + {{ADDR_W{1'b0}}, alloc} - {{ADDR_W{1'b0}}, free};
    end
  end
endmodule

// File: rtl/fflags_commit_drain.sv
// fflags_commit_drain: drains completed flag rows in order into a commit register
// and accumulates consumed flags into the sticky accrued value.
module fflags_commit_drain
  import fflags_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              R0_en,
  output logic [ADDR_W-1:0] R0_addr,
  input  logic [FLAG_W-1:0] R0_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [FLAG_W-1:0] commit_flags,
  output logic [FLAG_W-1:0] accrued,
  input  logic              csr_wen,
  input  logic [FLAG_W-1:0] csr_wdata,
  input  logic              flush
);
  logic              full, head_ready, load, consume;
  logic [ADDR_W-1:0] head, tail;
  logic [FLAG_W-1:0] consumed;
  commit_rec_t       rec;
  fflags_row_tracker u_trk (
    .clock      (clock),
    .reset_n    (reset_n),
    .alloc      (alloc_valid && alloc_ready),
    .free       (load),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .flush      (flush),
    .head       (head),
    .tail       (tail),
    .full       (full),
    .head_ready (head_ready)
  );
  assign alloc_ready  = !full;
  assign alloc_addr   = tail;
  assign consume      = commit_valid && commit_ready;
  assign load         = head_ready && (!commit_valid || commit_ready) && !flush;
  assign R0_en        = load;
  assign R0_addr      = head;
  assign commit_addr  = rec.addr;
  assign commit_flags = rec.flags;
  assign consumed     = consume ? rec.flags : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid <= 1'b0;
      rec          <= '0;
      accrued      <= '0;
    end else begin
      if (flush) commit_valid <= 1'b0;
      else if (load) begin
        commit_valid <= 1'b1;
        rec          <= '{addr: head, flags: R0_data};
      end else if (consume) commit_valid <= 1'b0;
      accrued <= (csr_wen ? csr_wdata : accrued) | consumed;
    end
  end
endmodule
